// File: rtl/uart_mmio_master.sv
// uart_mmio_master
// Bus initiator for the UART MMIO window (0x80 TX data, 0x81 RX data, 0x82 status).
// It drains a small TX byte FIFO into TX data writes. A write is issued only after a
// status poll has shown tx_busy (bit 0) low. Received bytes are fetched when a poll
// shows rx_ready (bit 1) and the local holding register is free.
//
// State table:
//   state | meaning
//   PGAP  | idle before the next status poll (max(POLL_GAP,1) cycles)
//   POLL  | read 0x82, decide READ / WRITE / PGAP from the returned status
//   READ  | read 0x81 into the RX holding register
//   WRITE | write FIFO head to 0x80, pop it
//   WGAP  | idle after a write so tx_busy has risen before the next poll
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   s_tx_valid/data/ready  byte stream in (to UART TX)
//   m_rx_valid/data/ready  byte stream out (from UART RX)
//   bus_cs/we/addr/wdata   registered MMIO access strobe and payload
//   bus_rdata              combinational read data from the slave
//   busy                   work pending or an access sequence in progress
module uart_mmio_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_GAP     = 2,
    parameter int POLL_GAP   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tx_valid,
    input  logic [7:0] s_tx_data,
    output logic       s_tx_ready,
    output logic       m_rx_valid,
    output logic [7:0] m_rx_data,
    input  logic       m_rx_ready,
    output logic       bus_cs,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    // Gap timers are down-counters; a zero gap still spends one cycle in the gap state.
    localparam logic [15:0] PGAP_LOAD = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
    localparam logic [15:0] WGAP_LOAD = (WR_GAP > 0) ? 16'(WR_GAP - 1) : 16'd0;

    typedef enum logic [2:0] {
        ST_PGAP,
        ST_POLL,
        ST_READ,
        ST_WRITE,
        ST_WGAP
    } state_t;

    state_t         state, state_nx;
    logic [15:0]    gap_cnt, gap_cnt_nx;
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, pop;

    // Ready comes from the pre-edge count, so a full FIFO being popped this cycle
    // still refuses the incoming byte.
    assign s_tx_ready = (count != CW'(FIFO_DEPTH));
    assign push       = s_tx_valid && s_tx_ready;
    assign pop        = (state == ST_WRITE);
    assign busy       = (count != '0) || m_rx_valid ||
                        (state == ST_READ) || (state == ST_WRITE) || (state == ST_WGAP);

    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        case (state)
            ST_PGAP: begin
                if (gap_cnt == '0) state_nx = ST_POLL;
                else               gap_cnt_nx = gap_cnt - 16'd1;
            end
            ST_POLL: begin
                // RX wins: the slave holds only one received byte.
                if (bus_rdata[1] && !m_rx_valid) begin
                    state_nx = ST_READ;
                end else if (!bus_rdata[0] && (count != '0)) begin
                    state_nx = ST_WRITE;
                end else begin
                    state_nx   = ST_PGAP;
                    gap_cnt_nx = PGAP_LOAD;
                end
            end
            ST_READ: begin
                state_nx   = ST_PGAP;
                gap_cnt_nx = PGAP_LOAD;
            end
            ST_WRITE: begin
                state_nx   = ST_WGAP;
                gap_cnt_nx = WGAP_LOAD;
            end
            ST_WGAP: begin
                if (gap_cnt == '0) begin
                    state_nx   = ST_PGAP;
                    gap_cnt_nx = PGAP_LOAD;
                end else begin
                    gap_cnt_nx = gap_cnt - 16'd1;
                end
            end
            default: begin
                state_nx   = ST_PGAP;
                gap_cnt_nx = PGAP_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_PGAP;
            gap_cnt    <= '0;
            bus_cs     <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 8'h00;
            bus_wdata  <= 8'h00;
            m_rx_valid <= 1'b0;
            m_rx_data  <= 8'h00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_cnt_nx;

            // Bus outputs are registered from the next state so they line up with it.
            bus_cs <= (state_nx == ST_POLL) || (state_nx == ST_READ) || (state_nx == ST_WRITE);
            bus_we <= (state_nx == ST_WRITE);
            case (state_nx)
                ST_POLL:  bus_addr <= 8'h82;
                ST_READ:  bus_addr <= 8'h81;
                ST_WRITE: begin
                    bus_addr  <= 8'h80;
                    // WRITE is entered only from POLL with a non-empty FIFO, so the head is valid.
                    bus_wdata <= fifo_mem[rd_ptr];
                end
                default: ;
            endcase

            if (state == ST_READ) begin
                m_rx_data  <= bus_rdata;
                m_rx_valid <= 1'b1;
            end else if (m_rx_ready) begin
                m_rx_valid <= 1'b0;
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifo_mem[wr_ptr] <= s_tx_data;
    end
endmodule

// File: tb/tb_uart_mmio_master.sv
module tb_uart_mmio_master;
    localparam int DEPTH    = 4;
    localparam int WGAP_LEN = 2;
    localparam int K_POLL   = 0;
    localparam int K_READ   = 1;
    localparam int K_WRITE  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tx_valid;
    logic [7:0] s_tx_data;
    logic       s_tx_ready;
    logic       m_rx_valid;
    logic [7:0] m_rx_data;
    logic       m_rx_ready;
    logic       bus_cs;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       busy;

    // Slave register window: status and RX data are set directly by the stimulus.
    logic [7:0] status;
    logic [7:0] rx_byte;

    uart_mmio_master dut (
        .clk(clk), .rst(rst),
        .s_tx_valid(s_tx_valid), .s_tx_data(s_tx_data), .s_tx_ready(s_tx_ready),
        .m_rx_valid(m_rx_valid), .m_rx_data(m_rx_data), .m_rx_ready(m_rx_ready),
        .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus_rdata = 8'h00;
        if (bus_cs && !bus_we) begin
            if (bus_addr == 8'h82)      bus_rdata = status;
            else if (bus_addr == 8'h81) bus_rdata = rx_byte;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the next bus access the rules predict, how many idle cycles
    // precede it, the queue of accepted bytes and the RX holding register.
    logic [7:0] q[$];
    int         exp_kind;
    int         wait_n;
    bit         after_write;
    bit         rxv;
    logic [7:0] rxd;
    int         n_reads  = 0;
    int         n_writes = 0;

    task automatic model_reset();
        q.delete();
        rxv         = 1'b0;
        rxd         = 8'h00;
        exp_kind    = K_POLL;
        wait_n      = 1;
        after_write = 1'b0;
    endtask

    task automatic mon_step();
        bit   ready_exp, busy_exp;
        int   cur;
        logic [7:0] addr_exp;
        ready_exp = (q.size() < DEPTH);
        cur       = (wait_n == 0) ? exp_kind : -1;
        busy_exp  = (q.size() != 0) || rxv || cur == K_READ || cur == K_WRITE ||
                    (after_write && wait_n > 1);
        chk("s_tx_ready", s_tx_ready, ready_exp);
        chk("m_rx_valid", m_rx_valid, rxv);
        chk("m_rx_data", m_rx_data, rxd);
        chk("busy", busy, busy_exp);
        if (wait_n > 0) begin
            chk("bus_idle_cs", bus_cs, 0);
        end else begin
            addr_exp = (exp_kind == K_POLL) ? 8'h82 : (exp_kind == K_READ) ? 8'h81 : 8'h80;
            chk("bus_cs", bus_cs, 1);
            chk("bus_we", bus_we, exp_kind == K_WRITE);
            chk("bus_addr", bus_addr, addr_exp);
            if (exp_kind == K_WRITE) chk("bus_wdata", bus_wdata, (q.size() != 0) ? q[0] : 8'h00);
        end
        if (bus_cs && bus_we) n_writes++;
        if (bus_cs && !bus_we && bus_addr == 8'h81) n_reads++;

        if (rst) begin
            model_reset();
            return;
        end
        if (wait_n > 0) begin
            wait_n--;
        end else begin
            case (exp_kind)
                K_POLL: begin
                    after_write = 1'b0;
                    if (status[1] && !rxv)               exp_kind = K_READ;
                    else if (!status[0] && q.size() != 0) exp_kind = K_WRITE;
                    else begin exp_kind = K_POLL; wait_n = 1; end
                end
                K_READ: begin
                    exp_kind = K_POLL; wait_n = 1; after_write = 1'b0;
                end
                default: begin
                    if (q.size() != 0) void'(q.pop_front());
                    exp_kind = K_POLL; wait_n = WGAP_LEN + 1; after_write = 1'b1;
                end
            endcase
        end
        if (cur == K_READ) begin
            rxv = 1'b1;
            rxd = rx_byte;
        end else if (m_rx_ready) begin
            rxv = 1'b0;
        end
        if (s_tx_valid && ready_exp) q.push_back(s_tx_data);
    endtask

    // One clock: model samples mid-cycle, stimulus changes 1 time unit after the edge.
    task automatic tick();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] status;
        logic [7:0] rx_byte;
        bit         rx_take;
        int         push_n;
        logic [7:0] push_data;
        int         cycles;
        bit         exp_rxv;
        logic [7:0] exp_rxd;
        bit         exp_ready;
        bit         exp_busy;
        int         exp_reads;
        int         exp_writes;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int r0, w0;
        bit found;

        vecs[0] = '{8'hFC, 8'h00, 1'b0, 0, 8'h00, 8,  1'b0, 8'h00, 1'b1, 1'b0, 0, 0};
        vecs[1] = '{8'h00, 8'h00, 1'b0, 1, 8'h55, 8,  1'b0, 8'h00, 1'b1, 1'b0, 0, 1};
        vecs[2] = '{8'hFD, 8'h00, 1'b0, 1, 8'hA5, 10, 1'b0, 8'h00, 1'b1, 1'b1, 0, 0};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 0, 8'h00, 8,  1'b0, 8'h00, 1'b1, 1'b0, 0, 1};
        vecs[4] = '{8'h02, 8'h3C, 1'b0, 0, 8'h00, 10, 1'b1, 8'h3C, 1'b1, 1'b1, 1, 0};
        vecs[5] = '{8'h02, 8'h3C, 1'b0, 0, 8'h00, 10, 1'b1, 8'h3C, 1'b1, 1'b1, 0, 0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 0, 8'h00, 6,  1'b0, 8'h3C, 1'b1, 1'b0, 0, 0};
        vecs[7] = '{8'h02, 8'h77, 1'b0, 1, 8'h11, 12, 1'b1, 8'h77, 1'b1, 1'b1, 1, 1};
        vecs[8] = '{8'h00, 8'h00, 1'b1, 0, 8'h00, 6,  1'b0, 8'h77, 1'b1, 1'b0, 0, 0};
        vecs[9] = '{8'h01, 8'h00, 1'b0, 5, 8'hC0, 7,  1'b0, 8'h77, 1'b0, 1'b1, 0, 0};

        rst = 1'b1; s_tx_valid = 1'b0; s_tx_data = 8'h00; m_rx_ready = 1'b0;
        status = 8'h00; rx_byte = 8'h00;
        model_reset();

        @(posedge clk); #1;
        chk("rst_bus_cs", bus_cs, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 8'h00);
        chk("rst_bus_wdata", bus_wdata, 8'h00);
        chk("rst_m_rx_valid", m_rx_valid, 0);
        chk("rst_m_rx_data", m_rx_data, 8'h00);
        chk("rst_s_tx_ready", s_tx_ready, 1);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            r0 = n_reads;
            w0 = n_writes;
            status  = vecs[i].status;
            rx_byte = vecs[i].rx_byte;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                s_tx_valid = (c < vecs[i].push_n);
                s_tx_data  = vecs[i].push_data + 8'(c);
                m_rx_ready = (c == 0) && vecs[i].rx_take;
                tick();
            end
            s_tx_valid = 1'b0;
            m_rx_ready = 1'b0;
            chk($sformatf("v%0d_rx_valid", i), m_rx_valid, vecs[i].exp_rxv);
            chk($sformatf("v%0d_rx_data", i), m_rx_data, vecs[i].exp_rxd);
            chk($sformatf("v%0d_tx_ready", i), s_tx_ready, vecs[i].exp_ready);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("v%0d_reads", i), n_reads - r0, vecs[i].exp_reads);
            chk($sformatf("v%0d_writes", i), n_writes - w0, vecs[i].exp_writes);
        end

        // FIFO is full of C0..C3; release tx_busy and reset in the middle of the first write.
        status = 8'h00;
        found  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus_cs && bus_we) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_write_seen", found, 1);
        chk("mid_write_data", bus_wdata, 8'hC0);
        rst = 1'b1;
        tick();
        chk("post_rst_bus_cs", bus_cs, 0);
        chk("post_rst_tx_ready", s_tx_ready, 1);
        chk("post_rst_busy", busy, 0);
        rst = 1'b0;
        w0 = n_writes;
        for (int k = 0; k < 10; k++) tick();
        chk("post_rst_writes", n_writes - w0, 0);

        for (int i = 0; i < 3000; i++) begin
            status     = 8'($urandom);
            rx_byte    = 8'($urandom);
            s_tx_valid = 1'($urandom_range(0, 1));
            s_tx_data  = 8'($urandom);
            m_rx_ready = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
